// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants for the prefetching instruction-fetch stage.
// Widths, PC step and reset level used by the stage and its FIFO.
package if_prefetch_unit_pkg;

  localparam int   INST_ADDR_W = 32;
  localparam int   INST_W      = 32;
  localparam int   INST_BYTES  = 4;
  localparam logic RST_ENABLE  = 1'b0;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} pairs for ID.
// Head is read straight from storage; reads as zero while empty.
module fetch_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !clr;
  assign do_pop  = pop && !clr && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && rst != RST_ENABLE)
      mem[wr_ptr] <= din;
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst == RST_ENABLE)
    !(pop && !clr && empty));

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: credit-limited pipelined ROM requests,
// in-order response buffering, redirect flush with stale-word discard.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                DATA_W   = INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_gnt_i,
  input  logic              rom_rvalid_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int                CW   = cnt_w(DEPTH);
  localparam int                FW   = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     out_nxt;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [FW-1:0]     head;

  assign target      = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  // Words in flight plus words buffered never exceed FIFO capacity.
  assign rom_req_o  = (rst != RST_ENABLE) && !redirect_i
                   && (credit_used < (CW+1)'(DEPTH));
  assign rom_addr_o = fpc;

  assign issue = rom_req_o && rom_gnt_i;
  assign resp  = rom_rvalid_i && (outstanding != '0);
  assign push  = resp && !redirect_i && (discard == '0);
  assign pop   = id_valid_o && id_ready_i && !redirect_i;

  always_comb begin
    out_nxt = outstanding;
    unique case ({issue, resp})
      2'b10:   out_nxt = outstanding + CW'(1);
      2'b01:   out_nxt = outstanding - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fpc         <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_i) begin
        // Everything still in flight belongs to the old path.
        fpc     <= target;
        resp_pc <= target;
        discard <= out_nxt;
      end else begin
        if (issue) fpc <= fpc + STEP;
        if (push)  resp_pc <= resp_pc + STEP;
        if (resp && discard != '0)
          discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_i),
    .push  (push),
    .din   ({resp_pc, rom_data_i}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

  assign id_valid_o           = !empty;
  assign {id_pc_o, id_inst_o} = head;

  a_credit: assert property (
    @(posedge clk) disable iff (rst == RST_ENABLE)
    credit_used <= (CW+1)'(DEPTH));

  a_rvalid_orphan: assert property (
    @(posedge clk) disable iff (rst == RST_ENABLE)
    !(rom_rvalid_i && outstanding == '0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst == RST_ENABLE)
    !(push && full && !pop));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: ROM model, ID monitor,
// directed stall / redirect / wrap / mid-stream reset scenarios.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_gnt;
  logic        rom_rvalid;
  logic [31:0] rom_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_rvalid;
  logic [31:0] hi_data;
  logic        hi_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_inst;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int issue_cnt;
  int now_cyc  = 0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .rom_req_o     (rom_req),
    .rom_addr_o    (rom_addr),
    .rom_gnt_i     (rom_gnt),
    .rom_rvalid_i  (rom_rvalid),
    .rom_data_i    (rom_data),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  if_prefetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_hi (
    .clk           (clk),
    .rst           (rst),
    .rom_req_o     (hi_req),
    .rom_addr_o    (hi_addr),
    .rom_gnt_i     (1'b1),
    .rom_rvalid_i  (hi_rvalid),
    .rom_data_i    (hi_data),
    .id_valid_o    (hi_valid),
    .id_ready_i    (1'b1),
    .id_pc_o       (hi_pc),
    .id_inst_o     (hi_inst),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input bit rdy);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    rom_gnt  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    issue_cnt = 0;
    rst       = 1'b1;
    id_ready  = rdy;
  endtask

  // ROM with programmable in-order latency; shares the reset
  initial begin
    rom_rvalid = 1'b0;
    rom_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
      end else if (rom_req && rom_gnt) begin
        pend.push_back('{a: rom_addr, due: now_cyc + lat});
        issue_cnt++;
      end
      @(posedge clk);
      #1;
      now_cyc++;
      rom_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= now_cyc) begin
        rom_rvalid = 1'b1;
        rom_data   = rom_word(pend[0].a);
        void'(pend.pop_front());
      end
    end
  end

  // Single-cycle ROM for the wrap-around instance
  initial begin
    logic        iss;
    logic [31:0] a;
    hi_rvalid = 1'b0;
    hi_data   = '0;
    forever begin
      @(negedge clk);
      iss = rst && hi_req;
      a   = hi_addr;
      @(posedge clk);
      #1;
      hi_rvalid = iss;
      hi_data   = rom_word(a);
    end
  end

  // ID-side monitor
  initial begin
    logic        hold = 1'b0;
    logic [31:0] hpc;
    logic [31:0] hinst;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (hold && rst) begin
        chk("hold_valid", 32'(id_valid), 32'd1);
        chk("hold_pc", id_pc, hpc);
        chk("hold_inst", id_inst, hinst);
      end
      hold  = rst && !redirect && id_valid && !id_ready;
      hpc   = id_pc;
      hinst = id_inst;
      if (rst && !redirect && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got pc %h expected none", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_inst", id_inst, rom_word(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0;
    logic [31:0] hexp [3];
    hexp[0] = 32'hFFFF_FFF8;
    hexp[1] = 32'hFFFF_FFFC;
    hexp[2] = 32'h0000_0000;

    rst         = 1'b0;
    rom_gnt     = 1'b1;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    issue_cnt   = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);

    // streaming, latency 1
    lat = 1;
    do_reset(1'b1);
    push_run(32'h0, 16);
    @(negedge clk);
    chk("t1_req_c1", 32'(rom_req), 32'd1);
    chk("t1_addr_c1", rom_addr, 32'h0);
    @(negedge clk);
    chk("t1_valid_c2", 32'(id_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c3", 32'(id_valid), 32'd1);
    wait_drain("t1_drain", 60);

    // ID stall fills exactly DEPTH words
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    chk("t2_issued", 32'(issue_cnt), 32'd4);
    chk("t2_req_off", 32'(rom_req), 32'd0);
    chk("t2_valid", 32'(id_valid), 32'd1);
    chk("t2_head_pc", id_pc, 32'h0);
    push_run(32'h0, 5);
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t2_no_gap", 32'(id_valid), 32'd1);
    end
    wait_drain("t2_drain", 20);

    // redirect with three words outstanding, latency 3
    lat = 3;
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    push_run(32'h100, 4);
    @(negedge clk);
    chk("t3_req_redirect", 32'(rom_req), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_valid_r1", 32'(id_valid), 32'd0);
    wait_drain("t3_drain", 60);

    // redirect colliding with pop and rvalid, unaligned target
    lat = 1;
    do_reset(1'b1);
    push_run(32'h0, 6);
    wait_drain("t4_pre_drain", 40);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    push_run(32'h200, 4);
    @(negedge clk);
    chk("t4_valid_at_r", 32'(id_valid), 32'd1);
    chk("t4_req_at_r", 32'(rom_req), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_valid_r1", 32'(id_valid), 32'd0);
    wait_drain("t4_drain", 40);

    // gnt withheld: request held stable, then redirected
    @(posedge clk);
    #1;
    id_ready = 1'b0;
    rom_gnt  = 1'b0;
    @(negedge clk);
    a0 = rom_addr;
    chk("t5_req_c0", 32'(rom_req), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("t5_req_held", 32'(rom_req), 32'd1);
      chk("t5_addr_held", rom_addr, a0);
    end
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    chk("t5_req_drop", 32'(rom_req), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("t5_req_back", 32'(rom_req), 32'd1);
    chk("t5_addr_target", rom_addr, 32'h400);
    @(posedge clk);
    #1;
    push_run(32'h400, 4);
    rom_gnt  = 1'b1;
    id_ready = 1'b1;
    wait_drain("t5_drain", 40);
    @(posedge clk);
    #1;
    id_ready = 1'b0;

    // address wrap from RESET_PC near the top, then mid-stream reset
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_hi_valid", 32'(hi_valid), 32'd1);
      chk("t6_hi_pc", hi_pc, hexp[i]);
      chk("t6_hi_inst", hi_inst, rom_word(hexp[i]));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_req", 32'(rom_req), 32'd0);
    chk("t6_addr", rom_addr, 32'h0);
    chk("t6_valid", 32'(id_valid), 32'd0);
    chk("t6_pc", id_pc, 32'h0);
    chk("t6_inst", id_inst, 32'h0);
    chk("t6_hi_req", 32'(hi_req), 32'd0);
    chk("t6_hi_addr", hi_addr, 32'hFFFF_FFF8);
    chk("t6_hi_valid_rst", 32'(hi_valid), 32'd0);
    chk("t6_hi_pc_rst", hi_pc, 32'h0);
    chk("t6_hi_inst_rst", hi_inst, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
